branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped branch target buffer (BTB) with 2-bit saturating-counter prediction
//  for the pipelined datapath. Sits beside program_counter: fetch PC looked up
//  combinationally each cycle, predicted next PC fed to pc_next mux; EX stage resolves
//  branches/jumps, reports outcome here, receives mispredict + redirect PC.
// PARAMETERS
//  ENTRIES  16  number of BTB entries, power of two, >=2; IDX_W = $clog2(ENTRIES)
//  CTR_W    2   saturating counter width; predict taken when counter MSB = 1
//  TAG_W    30-IDX_W  derived (localparam): tag = pc[31:IDX_W+2]
// PORTS
//  CLK           in   1   clock, all state updates on rising edge
//  RST           in   1   asynchronous reset, active high
//  fetch_pc      in   32  PC currently presented to imem
//  pred_hit      out  1   valid entry with matching tag for fetch_pc
//  pred_taken    out  1   pred_hit && counter MSB
//  pred_target   out  32  predicted next PC: stored target if pred_taken, else fetch_pc+4
//  upd_valid     in   1   EX holds a resolved control-flow instruction this cycle (pre-gated with ihit, !flush)
//  upd_pc        in   32  PC of resolved instruction
//  upd_taken     in   1   actual outcome (jumps always 1)
//  upd_target    in   32  actual taken target
//  ex_pred_taken in   1   prediction carried down pipeline with the instruction
//  ex_pred_target in  32  predicted next PC carried down pipeline
//  mispredict    out  1   EX must flush IF/ID and ID/EX and redirect
//  redirect_pc   out  32  correct next PC: upd_taken ? upd_target : upd_pc+4
//  stat_lookups  out  32  (BTB_STATS_EN only) resolved branches counted
//  stat_mispred  out  32  (BTB_STATS_EN only) mispredictions counted
// BEHAVIOUR
//  Reset: all valid bits 0, counters 2'b01 (weak not-taken), targets/tags 0; stats 0.
//   Combinational outputs follow reset state: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4.
//  Lookup: purely combinational, zero latency; idx = fetch_pc[IDX_W+1:2].
//  mispredict = upd_valid && (actual_next != predicted_next) where
//   actual_next = redirect_pc; predicted_next = ex_pred_taken ? ex_pred_target : upd_pc+4.
//   Combinational, zero latency; 0 whenever upd_valid=0.
//  Update (registered, on CLK edge when upd_valid=1), idx/tag from upd_pc:
//   hit & taken:   counter = sat_inc(counter); target = upd_target
//   hit & !taken:  counter = sat_dec(counter); target unchanged
//   miss & taken:  allocate: valid=1, tag, target=upd_target, counter=2'b10 (weak taken)
//   miss & !taken: no change (no allocate on not-taken)
//  Saturation: counter holds at all-ones on inc, at zero on dec; never wraps.
//  Simultaneous lookup + update to same index: lookup returns pre-update contents
//   (no write-through bypass); new contents visible the following cycle.
//  Aliasing: differing tag overwrites entry (direct-mapped, no victim).
//  PC arithmetic: 32-bit, +4 wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
//  upd_valid with upd_pc[1:0]!=0: low bits ignored, treated as aligned.
//  RST asserted mid-operation: table cleared immediately (async); outputs as reset.
// CONFIGURATION
//  BTB_STATS_EN defined: two 32-bit counters; stat_lookups += 1 per upd_valid cycle,
//   stat_mispred += 1 per mispredict cycle; both saturate at 32'hFFFFFFFF; reset to 0.
//  BTB_STATS_EN undefined: stat_* ports absent, no counter logic synthesised.
// STRUCTURE
//  cpu_types_pkg: btb_entry_t {valid, tag, target word_t, ctr}, BTB_CTR_RESET=2'b01,
//   BTB_CTR_ALLOC=2'b10 constants.
//  One sub-module: sat_counter (parametrised CTR_W, inputs cur, inc, dec -> next),
//   instantiated once on update path.
// TESTING
//  Reset, fetch_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
//  Update pc=0x40 taken target=0x100, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x100;
//   next cycle fetch_pc=0x40 -> pred_hit=1, pred_taken=1, pred_target=0x100.
//  Same branch not-taken twice -> counter 10->01->00; fetch 0x40 -> pred_taken=0, pred_target=0x44;
//   third not-taken holds 00; 3 takens -> 01,10,11, fourth holds 11.
//  ENTRIES=16: allocate 0x40 then taken at 0x80 (same idx) -> 0x40 misses, 0x80 hits.
//  Lookup and update same idx same cycle -> lookup shows old entry; next cycle shows new.
//  BTB_STATS_EN: 5 updates, 2 mispredicts -> stat_lookups=5, stat_mispred=2; RST mid-run -> 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: machine word and BTB entry layout.
// The BTB counter width is fixed here and must match the BTB's CTR_W parameter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BTB_CTR_W = 2;
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_RESET = 2'b01;  // weak not-taken
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_ALLOC = 2'b10;  // weak taken

    // Tag is stored zero-extended to the widest possible tag (ENTRIES = 1).
    typedef struct packed {
        logic                 valid;
        logic [29:0]          tag;
        word_t                target;
        logic [BTB_CTR_W-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter step: next = cur +1 / -1, clamped at all-ones / zero.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] next
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next = cur;
        if (inc && (cur != {CTR_W{1'b1}})) begin
            next = cur + 1'b1;
        end else if (dec && (cur != '0)) begin
            next = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating prediction, combinational lookup and EX-stage update.
// Optional `define BTB_STATS_EN adds saturating resolved-branch and misprediction counters.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = BTB_CTR_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispred
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    function automatic logic [29:0] tag_of(input word_t pc);
        tag_of = '0;
        tag_of[TAG_W-1:0] = pc[31:IDX_W+2];
    endfunction

    btb_entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [29:0]      upd_tag;
    btb_entry_t       fetch_entry;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_next;
    word_t            upd_fallthrough;
    word_t            predicted_next;

    // Lookup reads the registered table only, so a same-cycle update is seen one cycle later.
    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign fetch_entry = table_q[fetch_idx];
    assign pred_hit    = fetch_entry.valid && (fetch_entry.tag == tag_of(fetch_pc));
    assign pred_taken  = pred_hit && fetch_entry.ctr[CTR_W-1];
    assign pred_target = pred_taken ? fetch_entry.target : fetch_pc + 32'd4;

    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = tag_of(upd_pc);
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    assign upd_fallthrough = upd_pc + 32'd4;
    assign redirect_pc     = upd_taken ? upd_target : upd_fallthrough;
    assign predicted_next  = ex_pred_taken ? ex_pred_target : upd_fallthrough;
    assign mispredict      = upd_valid && (redirect_pc != predicted_next);

    sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .cur  (upd_entry.ctr),
        .inc  (upd_taken),
        .dec  (!upd_taken),
        .next (ctr_next)
    );

    // NOTE: the table is small flop storage, so clearing it on reset is intended; a RAM could not do this.
    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_CTR_RESET};
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                table_q[upd_idx].ctr <= ctr_next;
                if (upd_taken) begin
                    table_q[upd_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                // Not-taken misses never allocate; taken misses evict whatever aliases here.
                table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target,
                                      ctr: BTB_CTR_ALLOC};
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (upd_valid && (stat_lookups != 32'hFFFF_FFFF)) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (mispredict && (stat_mispred != 32'hFFFF_FFFF)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized updates
// compared against an array-based reference model of the prediction table.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispred;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one slot per index, counter kept as a plain integer 0..3.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_pcline [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint      m_lookups;
    longint      m_mispred;

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .fetch_pc       (fetch_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups   (stat_lookups),
        .stat_mispred   (stat_mispred)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    // Two PCs share an entry exactly when they agree above the index bits.
    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_pcline[i] = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_lookups = 0;
        m_mispred = 0;
    endtask

    task automatic ref_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                              output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_pcline[i] == line_of(pc));
        tk  = hit && (m_ctr[i] >= 2);
        tgt = tk ? m_target[i] : pc + 32'd4;
    endtask

    task automatic check_stats(input string tag);
`ifdef BTB_STATS_EN
        check({tag, ".stat_lookups"}, stat_lookups, 32'(m_lookups));
        check({tag, ".stat_mispred"}, stat_mispred, 32'(m_mispred));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Present one cycle of inputs, check combinational outputs, then clock and update the model.
    task automatic apply(input string tag, input logic [31:0] fpc, input bit uv,
                         input logic [31:0] upc, input bit tk, input logic [31:0] utgt,
                         input bit ept, input logic [31:0] eptgt);
        bit          eh, et, emis;
        logic [31:0] etgt, act, prd;
        int          i;
        fetch_pc       = fpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = tk;
        upd_target     = utgt;
        ex_pred_taken  = ept;
        ex_pred_target = eptgt;
        #2;
        ref_lookup(fpc, eh, et, etgt);
        act  = tk ? utgt : upc + 32'd4;
        prd  = ept ? eptgt : upc + 32'd4;
        emis = uv && (act != prd);
        check({tag, ".pred_hit"},    32'(pred_hit),   32'(eh));
        check({tag, ".pred_taken"},  32'(pred_taken), 32'(et));
        check({tag, ".pred_target"}, pred_target,     etgt);
        check({tag, ".mispredict"},  32'(mispredict), 32'(emis));
        check({tag, ".redirect_pc"}, redirect_pc,     act);
        check_stats(tag);
        @(posedge CLK);
        #1;
        if (uv) begin
            i = idx_of(upc);
            if (m_valid[i] && m_pcline[i] == line_of(upc)) begin
                m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (tk) m_target[i] = utgt;
            end else if (tk) begin
                m_valid[i]  = 1'b1;
                m_pcline[i] = line_of(upc);
                m_target[i] = utgt;
                m_ctr[i]    = 2;
            end
            if (m_lookups < 64'hFFFF_FFFF) m_lookups++;
            if (emis && m_mispred < 64'hFFFF_FFFF) m_mispred++;
        end
    endtask

    task automatic idle(input string tag, input logic [31:0] fpc);
        apply(tag, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input bit tk,
                           input logic [31:0] tgt);
        apply(tag, pc, 1'b1, pc, tk, tgt, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] pcs [6];
        logic [31:0] pc, tgt, ptgt;
        bit          ph, pt, tk;

        pcs = '{32'h40, 32'h80, 32'h44, 32'h1000_0048, 32'hFFFF_FFFC, 32'h7C};
        fetch_pc = 32'h40; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; ex_pred_taken = 0; ex_pred_target = 0;

        // Reset state, visible while RST is still held.
        RST = 1'b1;
        model_clear();
        #3;
        check("reset.pred_hit",    32'(pred_hit),   32'd0);
        check("reset.pred_taken",  32'(pred_taken), 32'd0);
        check("reset.pred_target", pred_target,     32'h44);
        check("reset.mispredict",  32'(mispredict), 32'd0);
        check_stats("reset");
        @(posedge CLK);
        #3;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Allocation on a taken miss; the next lookup hits with weak-taken.
        resolve("alloc", 32'h40, 1'b1, 32'h100);
        idle("alloc_hit", 32'h40);

        // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10.
        resolve("nt1", 32'h40, 1'b0, 32'h0);
        idle("after_nt1", 32'h40);
        resolve("nt2", 32'h40, 1'b0, 32'h0);
        resolve("nt3_hold0", 32'h40, 1'b0, 32'h0);
        idle("after_nt3", 32'h40);
        resolve("t1", 32'h40, 1'b1, 32'h104);
        idle("after_t1", 32'h40);
        resolve("t2", 32'h40, 1'b1, 32'h108);
        resolve("t3", 32'h40, 1'b1, 32'h10C);
        resolve("t4_hold3", 32'h40, 1'b1, 32'h110);
        resolve("nt_from3", 32'h40, 1'b0, 32'h0);
        idle("after_sat", 32'h40);

        // Aliasing: 0x80 shares the index of 0x40 and evicts it.
        resolve("alias_alloc", 32'h80, 1'b1, 32'h200);
        idle("alias_old_miss", 32'h40);
        idle("alias_new_hit", 32'h80);

        // Lookup and update of the same entry in one cycle: old contents first, new next.
        apply("same_cycle", 32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h200);
        idle("same_cycle_next", 32'h80);

        // Misaligned update address indexes as if aligned; correct prediction is no mispredict.
        apply("misaligned", 32'h4C, 1'b1, 32'h4E, 1'b1, 32'h500, 1'b1, 32'h500);
        idle("misaligned_hit", 32'h4C);

        // PC wrap: fall-through of the top word is zero.
        resolve("wrap_nt", 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle("wrap_fetch", 32'hFFFF_FFFC);

        // Randomized traffic on a small PC set so entries hit, alias and saturate.
        for (int n = 0; n < 300; n++) begin
            pc  = pcs[$urandom_range(0, 5)];
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFC;
            ref_lookup(pc, ph, pt, ptgt);
            if ($urandom_range(0, 3) == 0) begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = $urandom;
            end
            apply("rand", pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 4) != 0),
                  pc, tk, tgt, pt, ptgt);
        end

        // Asynchronous reset mid-run clears table and statistics without a clock edge.
        resolve("pre_rst", 32'h40, 1'b1, 32'h600);
        fetch_pc  = 32'h40;
        upd_valid = 1'b0;
        RST = 1'b1;
        #1;
        model_clear();
        check("midrst.pred_hit",    32'(pred_hit),   32'd0);
        check("midrst.pred_target", pred_target,     32'h44);
        check_stats("midrst");
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Stats scenario: five updates, exactly two of them mispredicted.
        resolve("s1_mis", 32'h40, 1'b1, 32'h100);
        apply("s2_ok", 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        apply("s3_ok", 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        resolve("s4_mis", 32'h80, 1'b1, 32'h200);
        apply("s5_ok", 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h200);
        idle("stats_end", 32'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
